// File: rtl/sram_1r1w_arbiter.sv
// Two-client round-robin arbiter/sequencer for the sky130 1r1w 32x32 SRAM macro.
// Port 0 carries writes, port 1 carries reads; read data is captured one edge after issue.
module sram_1r1w_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  n_rst,

    input  logic                  a_wr_req,
    input  logic [ADDR_WIDTH-1:0] a_wr_addr,
    input  logic [DATA_WIDTH-1:0] a_wr_data,
    output logic                  a_wr_gnt,
    input  logic                  b_wr_req,
    input  logic [ADDR_WIDTH-1:0] b_wr_addr,
    input  logic [DATA_WIDTH-1:0] b_wr_data,
    output logic                  b_wr_gnt,

    input  logic                  a_rd_req,
    input  logic [ADDR_WIDTH-1:0] a_rd_addr,
    output logic                  a_rd_gnt,
    input  logic                  b_rd_req,
    input  logic [ADDR_WIDTH-1:0] b_rd_addr,
    output logic                  b_rd_gnt,

    output logic                  a_rd_valid,
    output logic                  b_rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,

    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1,

    output logic [7:0]            coll_cnt
);

    localparam int NCLI = 2;

    logic [NCLI-1:0]       wr_req;
    logic [NCLI-1:0]       rd_req;
    logic [ADDR_WIDTH-1:0] wr_addr [NCLI];
    logic [DATA_WIDTH-1:0] wr_data [NCLI];
    logic [ADDR_WIDTH-1:0] rd_addr [NCLI];
    logic [NCLI-1:0]       wr_gnt;
    logic [NCLI-1:0]       rd_gnt;

    logic                  wr_sel;
    logic                  wr_any;
    logic                  rd_sel;
    logic                  rd_cand;
    logic [ADDR_WIDTH-1:0] rd_cand_addr;
    logic                  collision;
    logic                  rd_any;

    logic                  wr_last_reg;
    logic                  rd_last_reg;
    logic                  p_valid_reg;
    logic                  p_owner_reg;
    logic [NCLI-1:0]       rd_valid_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic [7:0]            coll_cnt_reg;
    logic [7:0]            coll_cnt_next;

    assign wr_req     = {b_wr_req, a_wr_req};
    assign rd_req     = {b_rd_req, a_rd_req};
    assign wr_addr[0] = a_wr_addr;
    assign wr_addr[1] = b_wr_addr;
    assign wr_data[0] = a_wr_data;
    assign wr_data[1] = b_wr_data;
    assign rd_addr[0] = a_rd_addr;
    assign rd_addr[1] = b_rd_addr;

    // Select index 1 (client B) only when B alone asks, or both ask and A won last time.
    assign wr_sel = n_rst & ((wr_req == 2'b10) | ((wr_req == 2'b11) & ~wr_last_reg));
    assign wr_any = n_rst & (|wr_req);
    assign rd_sel = n_rst & ((rd_req == 2'b10) | ((rd_req == 2'b11) & ~rd_last_reg));
    assign rd_cand = n_rst & (|rd_req);

    assign sram_addr0   = wr_addr[wr_sel];
    assign sram_din0    = wr_data[wr_sel];
    assign rd_cand_addr = rd_addr[rd_sel];

    // A read to the word being written this cycle waits; the write always goes first.
    assign collision = wr_any & rd_cand & (rd_cand_addr == sram_addr0);
    assign rd_any    = rd_cand & ~collision;

    generate
        for (genvar gi = 0; gi < NCLI; gi++) begin : g_cli
            assign wr_gnt[gi] = wr_any & (wr_sel == 1'(gi));
            assign rd_gnt[gi] = rd_any & (rd_sel == 1'(gi));
        end
    endgenerate

    assign a_wr_gnt = wr_gnt[0];
    assign b_wr_gnt = wr_gnt[1];
    assign a_rd_gnt = rd_gnt[0];
    assign b_rd_gnt = rd_gnt[1];

    assign sram_csb0  = ~wr_any;
    assign sram_csb1  = ~rd_any;
    assign sram_addr1 = rd_cand_addr;

    assign coll_cnt_next = (collision && coll_cnt_reg != 8'hFF) ? coll_cnt_reg + 8'd1
                                                                : coll_cnt_reg;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_last_reg  <= 1'b1;
            rd_last_reg  <= 1'b1;
            p_valid_reg  <= 1'b0;
            p_owner_reg  <= 1'b0;
            rd_valid_reg <= '0;
            rd_data_reg  <= '0;
            coll_cnt_reg <= '0;
        end else begin
            if (wr_any) begin
                wr_last_reg <= wr_sel;
            end
            if (rd_any) begin
                rd_last_reg <= rd_sel;
            end
            coll_cnt_reg <= coll_cnt_next;
            p_valid_reg  <= rd_any;
            p_owner_reg  <= rd_sel;
            rd_valid_reg <= '0;
            // dout1 is only guaranteed until shortly after this edge, so grab it now.
            if (p_valid_reg) begin
                rd_data_reg               <= sram_dout1;
                rd_valid_reg[p_owner_reg] <= 1'b1;
            end
        end
    end

    assign a_rd_valid = rd_valid_reg[0];
    assign b_rd_valid = rd_valid_reg[1];
    assign rd_data    = rd_data_reg;
    assign coll_cnt   = coll_cnt_reg;

endmodule

// File: tb/tb_sram_1r1w_arbiter.sv
// Bench for sram_1r1w_arbiter: SRAM macro model, rule-level reference model,
// arbitration vector table, directed corner sequences and randomized traffic.
module tb_sram_1r1w_arbiter;

    localparam bit T = 1'b1;
    localparam bit F = 1'b0;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        a_wr_req, b_wr_req, a_rd_req, b_rd_req;
    logic [4:0]  a_wr_addr, b_wr_addr, a_rd_addr, b_rd_addr;
    logic [31:0] a_wr_data, b_wr_data;
    logic        a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt;
    logic        a_rd_valid, b_rd_valid;
    logic [31:0] rd_data;
    logic        sram_csb0, sram_csb1;
    logic [4:0]  sram_addr0, sram_addr1;
    logic [31:0] sram_din0, sram_dout1;
    logic [7:0]  coll_cnt;

    always #5 clk = ~clk;

    sram_1r1w_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .n_rst(n_rst),
        .a_wr_req(a_wr_req), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data), .a_wr_gnt(a_wr_gnt),
        .b_wr_req(b_wr_req), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data), .b_wr_gnt(b_wr_gnt),
        .a_rd_req(a_rd_req), .a_rd_addr(a_rd_addr), .a_rd_gnt(a_rd_gnt),
        .b_rd_req(b_rd_req), .b_rd_addr(b_rd_addr), .b_rd_gnt(b_rd_gnt),
        .a_rd_valid(a_rd_valid), .b_rd_valid(b_rd_valid), .rd_data(rd_data),
        .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1),
        .coll_cnt(coll_cnt)
    );

    // Macro model: read data appears after the issuing edge and is garbage one edge later.
    logic [31:0] macro_mem [32];
    always @(posedge clk) begin
        if (!sram_csb1) sram_dout1 <= macro_mem[sram_addr1];
        else            sram_dout1 <= $urandom;
        if (!sram_csb0) macro_mem[sram_addr0] <= sram_din0;
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          owner;
        logic [31:0] data;
        bit          known;
        int          due;
    } resp_t;

    int          vec_cnt = 0;
    int          errs = 0;
    int          cyc = 0;
    int          m_wr_last = 1;
    int          m_rd_last = 1;
    int          m_coll = 0;
    logic [31:0] gm [32];
    bit          gk [32];
    resp_t       rq [$];
    logic [31:0] m_rd_data = '0;
    bit          m_rd_known = 1'b1;
    int          e_w, e_r;
    bit          e_coll;
    logic [4:0]  e_waddr, e_raddr;
    logic [31:0] e_wdata;

    function automatic int pick(input logic ra, input logic rb, input int last);
        if (ra && rb) return (last == 0) ? 1 : 0;
        else if (ra) return 0;
        else if (rb) return 1;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare every output against the model in the middle of the cycle.
    task automatic sample();
        int  rc;
        bit  due;
        bit  exp_av, exp_bv;
        @(negedge clk);
        e_w     = n_rst ? pick(a_wr_req, b_wr_req, m_wr_last) : -1;
        e_waddr = (e_w == 1) ? b_wr_addr : a_wr_addr;
        e_wdata = (e_w == 1) ? b_wr_data : a_wr_data;
        rc      = n_rst ? pick(a_rd_req, b_rd_req, m_rd_last) : -1;
        e_raddr = (rc == 1) ? b_rd_addr : a_rd_addr;
        e_coll  = (e_w >= 0) && (rc >= 0) && (e_raddr == e_waddr);
        e_r     = e_coll ? -1 : rc;
        chk("a_wr_gnt", 32'(a_wr_gnt), 32'(e_w == 0));
        chk("b_wr_gnt", 32'(b_wr_gnt), 32'(e_w == 1));
        chk("a_rd_gnt", 32'(a_rd_gnt), 32'(e_r == 0));
        chk("b_rd_gnt", 32'(b_rd_gnt), 32'(e_r == 1));
        chk("csb0", 32'(sram_csb0), 32'(e_w < 0));
        chk("csb1", 32'(sram_csb1), 32'(e_r < 0));
        chk("addr0", 32'(sram_addr0), 32'(e_waddr));
        chk("din0", sram_din0, e_wdata);
        if (e_r >= 0) chk("addr1", 32'(sram_addr1), 32'(e_raddr));
        due    = (rq.size() > 0) && (rq[0].due == cyc);
        exp_av = due && (rq[0].owner == 0);
        exp_bv = due && (rq[0].owner == 1);
        if (due) begin
            m_rd_known = rq[0].known;
            m_rd_data  = rq[0].data;
            $display("rd resp owner=%s data=%h cycle=%0d", (rq[0].owner == 1) ? "B" : "A", rd_data, cyc);
            void'(rq.pop_front());
        end
        chk("a_rd_valid", 32'(a_rd_valid), 32'(exp_av));
        chk("b_rd_valid", 32'(b_rd_valid), 32'(exp_bv));
        if (m_rd_known) chk("rd_data", rd_data, m_rd_data);
        chk("coll_cnt", 32'(coll_cnt), 32'(m_coll));
    endtask

    task automatic advance();
        @(posedge clk);
        if (!n_rst) begin
            m_wr_last  = 1;
            m_rd_last  = 1;
            m_coll     = 0;
            rq.delete();
            m_rd_data  = '0;
            m_rd_known = 1'b1;
        end else begin
            if (e_r >= 0) begin
                rq.push_back('{owner: e_r, data: gm[e_raddr], known: gk[e_raddr], due: cyc + 2});
                m_rd_last = e_r;
            end
            if (e_w >= 0) begin
                gm[e_waddr] = e_wdata;
                gk[e_waddr] = 1'b1;
                m_wr_last   = e_w;
            end
            if (e_coll && m_coll < 255) m_coll++;
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        a_wr_req = 1'b0; b_wr_req = 1'b0; a_rd_req = 1'b0; b_rd_req = 1'b0;
    endtask

    // ---------------- arbitration vector table ----------------
    typedef struct {
        bit         aw, bw, ar, br;
        logic [4:0] awa, bwa, ara, bra;
        bit         eaw, ebw, ear, ebr;
        bit         ecsb0, ecsb1;
        int         ecoll;
    } vec_t;

    vec_t tbl [15];

    // Random-phase client state: requests stay up until granted.
    bit          pw_v [2];
    logic [4:0]  pw_a [2];
    logic [31:0] pw_d [2];
    bit          pr_v [2];
    logic [4:0]  pr_a [2];

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        tbl[0]  = '{T,T,T,T, 5'd1,5'd2,5'd10,5'd11, T,F,T,F, F,F, 0};
        tbl[1]  = '{T,T,T,T, 5'd1,5'd2,5'd10,5'd11, F,T,F,T, F,F, 0};
        tbl[2]  = '{T,T,T,T, 5'd1,5'd2,5'd10,5'd11, T,F,T,F, F,F, 0};
        tbl[3]  = '{T,T,T,T, 5'd1,5'd2,5'd10,5'd11, F,T,F,T, F,F, 0};
        tbl[4]  = '{T,T,T,T, 5'd1,5'd2,5'd10,5'd11, T,F,T,F, F,F, 0};
        tbl[5]  = '{T,T,T,T, 5'd1,5'd2,5'd10,5'd11, F,T,F,T, F,F, 0};
        tbl[6]  = '{F,T,F,T, 5'd1,5'd2,5'd10,5'd11, F,T,F,T, F,F, 0};
        tbl[7]  = '{F,T,F,T, 5'd1,5'd2,5'd10,5'd11, F,T,F,T, F,F, 0};
        tbl[8]  = '{T,F,T,F, 5'd1,5'd2,5'd10,5'd11, T,F,T,F, F,F, 0};
        tbl[9]  = '{F,F,F,F, 5'd1,5'd2,5'd10,5'd11, F,F,F,F, T,T, 0};
        tbl[10] = '{T,T,T,T, 5'd1,5'd2,5'd10,5'd11, F,T,F,T, F,F, 0};
        tbl[11] = '{T,F,F,T, 5'd7,5'd2,5'd10,5'd7,  T,F,F,F, F,T, 0};
        tbl[12] = '{T,T,T,T, 5'd3,5'd4,5'd5,5'd4,   F,T,T,F, F,F, 1};
        tbl[13] = '{T,T,T,T, 5'd8,5'd9,5'd8,5'd8,   T,F,F,F, F,T, 1};
        tbl[14] = '{T,T,T,T, 5'd8,5'd9,5'd8,5'd8,   F,T,F,T, F,F, 2};

        for (int i = 0; i < 32; i++) begin
            gm[i] = '0;
            gk[i] = 1'b0;
        end

        // Reset held with every request raised.
        n_rst = 1'b0;
        a_wr_req = 1'b1; b_wr_req = 1'b1; a_rd_req = 1'b1; b_rd_req = 1'b1;
        a_wr_addr = 5'd1; b_wr_addr = 5'd2; a_rd_addr = 5'd3; b_rd_addr = 5'd4;
        a_wr_data = 32'h1111_1111; b_wr_data = 32'h2222_2222;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("rst_gnts", 32'({a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt}), 32'h0);
            chk("rst_csb", 32'({sram_csb0, sram_csb1}), 32'h3);
            advance();
        end
        n_rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            a_wr_req = tbl[i].aw; b_wr_req = tbl[i].bw;
            a_rd_req = tbl[i].ar; b_rd_req = tbl[i].br;
            a_wr_addr = tbl[i].awa; b_wr_addr = tbl[i].bwa;
            a_rd_addr = tbl[i].ara; b_rd_addr = tbl[i].bra;
            a_wr_data = 32'hA000_0000 + 32'(i);
            b_wr_data = 32'hB000_0000 + 32'(i);
            sample();
            chk($sformatf("tbl%0d_gnts", i), 32'({a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt}),
                32'({tbl[i].eaw, tbl[i].ebw, tbl[i].ear, tbl[i].ebr}));
            chk($sformatf("tbl%0d_csb", i), 32'({sram_csb0, sram_csb1}), 32'({tbl[i].ecsb0, tbl[i].ecsb1}));
            chk($sformatf("tbl%0d_coll", i), 32'(coll_cnt), 32'(tbl[i].ecoll));
            advance();
        end
        idle();
        for (int i = 0; i < 3; i++) begin sample(); advance(); end
        chk("tbl_coll_final", 32'(coll_cnt), 32'd2);

        // Fresh reset, then single write followed by a read from the other client.
        n_rst = 1'b0; sample(); advance(); n_rst = 1'b1;
        a_wr_req = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'hDEAD_BEEF;
        sample(); chk("sw_wgnt", 32'(a_wr_gnt), 32'd1); advance();
        a_wr_req = 1'b0; b_rd_req = 1'b1; b_rd_addr = 5'd3;
        sample(); chk("sw_rgnt", 32'(b_rd_gnt), 32'd1); advance();
        b_rd_req = 1'b0;
        sample(); chk("sw_early", 32'(b_rd_valid), 32'd0); advance();
        sample();
        chk("sw_bvalid", 32'(b_rd_valid), 32'd1);
        chk("sw_avalid", 32'(a_rd_valid), 32'd0);
        chk("sw_data", rd_data, 32'hDEAD_BEEF);
        advance();

        // Same-address write and read in one cycle.
        a_wr_req = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h0000_0777;
        b_rd_req = 1'b1; b_rd_addr = 5'd7;
        sample();
        chk("col_wgnt", 32'(a_wr_gnt), 32'd1);
        chk("col_rstall", 32'(b_rd_gnt), 32'd0);
        advance();
        a_wr_req = 1'b0;
        sample();
        chk("col_rgnt", 32'(b_rd_gnt), 32'd1);
        chk("col_cnt", 32'(coll_cnt), 32'd1);
        advance();
        b_rd_req = 1'b0;
        sample(); advance();
        sample();
        chk("col_valid", 32'(b_rd_valid), 32'd1);
        chk("col_data", rd_data, 32'h0000_0777);
        advance();

        // Preload 0..7, then eight back-to-back reads.
        for (int i = 0; i < 8; i++) begin
            a_wr_req = 1'b1; a_wr_addr = 5'(i); a_wr_data = 32'h100 + 32'(i);
            sample(); advance();
        end
        a_wr_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            a_rd_req  = (k < 8);
            a_rd_addr = 5'(k % 8);
            sample();
            if (k < 8) chk($sformatf("pipe_gnt%0d", k), 32'(a_rd_gnt), 32'd1);
            if (k >= 2) begin
                chk($sformatf("pipe_valid%0d", k - 2), 32'(a_rd_valid), 32'd1);
                chk($sformatf("pipe_data%0d", k - 2), rd_data, 32'h100 + 32'(k - 2));
            end
            advance();
        end

        // Reset in the cycle right after a read grant drops the response.
        a_rd_req = 1'b1; a_rd_addr = 5'd2;
        sample(); chk("mr_gnt", 32'(a_rd_gnt), 32'd1); advance();
        a_rd_req = 1'b0; n_rst = 1'b0;
        sample(); advance();
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("mr_valid", 32'({a_rd_valid, b_rd_valid}), 32'd0);
            chk("mr_data", rd_data, 32'd0);
            advance();
        end

        // A write stream that starves a same-address read saturates the counter.
        a_wr_req = 1'b1; a_wr_addr = 5'd5;
        b_rd_req = 1'b1; b_rd_addr = 5'd5;
        for (int i = 0; i < 260; i++) begin
            a_wr_data = 32'h5500_0000 + 32'(i);
            sample(); advance();
        end
        idle();
        sample(); chk("coll_sat", 32'(coll_cnt), 32'd255); advance();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 2; c++) begin
            pw_v[c] = 1'b0; pr_v[c] = 1'b0;
            pw_a[c] = '0; pw_d[c] = '0; pr_a[c] = '0;
        end
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (!pw_v[c] && $urandom_range(0, 9) < 6) begin
                    pw_v[c] = 1'b1; pw_a[c] = rnd_addr(); pw_d[c] = $urandom;
                end
                if (!pr_v[c] && $urandom_range(0, 9) < 6) begin
                    pr_v[c] = 1'b1; pr_a[c] = rnd_addr();
                end
            end
            n_rst = ($urandom_range(0, 199) != 0);
            a_wr_req = pw_v[0]; a_wr_addr = pw_a[0]; a_wr_data = pw_d[0];
            b_wr_req = pw_v[1]; b_wr_addr = pw_a[1]; b_wr_data = pw_d[1];
            a_rd_req = pr_v[0]; a_rd_addr = pr_a[0];
            b_rd_req = pr_v[1]; b_rd_addr = pr_a[1];
            sample();
            advance();
            if (e_w >= 0) pw_v[e_w] = 1'b0;
            if (e_r >= 0) pr_v[e_r] = 1'b0;
        end
        n_rst = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) begin sample(); advance(); end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, errs);
        $finish;
    end

endmodule

// File: doc/sram_1r1w_arbiter.md
# sram_1r1w_arbiter

Two-client arbiter and sequencer for the `sky130_sram_1r1w_32x32_32` macro. Client A and client B each have an independent write channel and read channel, using a req/gnt handshake. Writes and reads are arbitrated round-robin on their own ports. The block drives both macro ports from one clock, avoids same-address read/write collisions, captures `dout1` before the macro's hold window closes, and routes each read response back to its owner.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width; must match the macro.
- `ADDR_WIDTH`, 5, address width; must match the macro.

Ports:
- `clk`  in  1  single clock; also drives macro `clk0` and `clk1`.
- `n_rst`  in  1  reset; synchronous, active-low.
- `a_wr_req`, `b_wr_req`  in  1  write request; held with its address and data stable until granted.
- `a_wr_addr`, `b_wr_addr`  in  ADDR_WIDTH  write address.
- `a_wr_data`, `b_wr_data`  in  DATA_WIDTH  write data.
- `a_wr_gnt`, `b_wr_gnt`  out  1  write accepted this cycle (combinational).
- `a_rd_req`, `b_rd_req`  in  1  read request; held with its address until granted.
- `a_rd_addr`, `b_rd_addr`  in  ADDR_WIDTH  read address.
- `a_rd_gnt`, `b_rd_gnt`  out  1  read accepted this cycle (combinational).
- `a_rd_valid`, `b_rd_valid`  out  1  one-cycle pulse; read data is valid.
- `rd_data`  out  DATA_WIDTH  shared registered read data; qualified by `x_rd_valid`.
- `sram_csb0`  out  1  macro write chip select, active-low.
- `sram_addr0`  out  ADDR_WIDTH  macro write address.
- `sram_din0`  out  DATA_WIDTH  macro write data.
- `sram_csb1`  out  1  macro read chip select, active-low.
- `sram_addr1`  out  ADDR_WIDTH  macro read address.
- `sram_dout1`  in  DATA_WIDTH  macro read data.
- `coll_cnt`  out  8  saturating count of reads stalled by a collision.

## Operation
- A transfer occurs at the rising edge that ends a cycle in which both `req` and `gnt` are high.
- Write arbitration:
  - If exactly one client requests, that client is granted.
  - If both request, the client not granted last on the write port is granted.
  - `wr_last` is updated on every write grant.
  - `sram_csb0` = !(`a_wr_gnt` | `b_wr_gnt`). `sram_addr0` and `sram_din0` are muxed from the granted client; when idle they hold client A's values.
- Read arbitration uses the same round-robin scheme with its own pointer, `rd_last`.
- Collision rule:
  - If a write is granted and the read candidate's address equals `sram_addr0`, no read is granted that cycle and `rd_last` is unchanged.
  - The write proceeds.
  - `coll_cnt` increments, saturating at 255.
- Read pipeline:
  - On acceptance, set `p_valid`=1 and `p_owner` to the granted client.
  - On the next edge, if `p_valid`, capture `sram_dout1` into `rd_data` and pulse `a_rd_valid` or `b_rd_valid` for one cycle.
  - `rd_data` holds until the next capture.
- Back-to-back reads are fully pipelined, one per cycle.
- Ordering: a write accepted at edge c is visible to a read accepted at edge c+1 or later.

## Timing
- Reset (`n_rst` low at an edge):
  - `p_valid`=0, `a_rd_valid`=`b_rd_valid`=0, `rd_data`=0, `coll_cnt`=0.
  - `wr_last`=`rd_last`=B, so A has first priority.
- While `n_rst` is low, all grants are forced to 0 and `sram_csb0`=`sram_csb1`=1.
- Reset mid-read drops any pending response; no valid pulse is produced after reset.
- Read latency: accepted in cycle c → `x_rd_valid` high in cycle c+2 → `rd_data` stable from edge c+1 until the next capture.
- Write latency: `sram_*0` are presented combinationally in the grant cycle; the macro samples them at the edge and writes at the following falling edge.
- `sram_dout1` is sampled only at the edge after the read is issued, before the macro's hold delay expires.
- Grants depend only on current `req`/`addr`/`n_rst` and the registered pointers; there is no combinational path from `sram_dout1`.

## Test plan
- Reset: hold `n_rst`=0 for 3 cycles with all reqs high → all grants 0, `csb0`=`csb1`=1, `coll_cnt`=0; the first grant after release goes to A on both ports.
- Single write/read: A writes 0xDEADBEEF to addr 3; B reads addr 3 the next cycle → `b_rd_valid` pulses 2 cycles after the grant, `rd_data`=0xDEADBEEF, `a_rd_valid` stays 0.
- Round-robin: both clients hold `wr_req` for 6 cycles → grants alternate A,B,A,B,A,B; the same holds on the read port.
- Collision: A writes addr 7 while B reads addr 7 in the same cycle → B's read is stalled 1 cycle, `coll_cnt`=1, and the returned data is the new value.
- Pipelined reads: A reads addrs 0..7 on consecutive cycles with preloaded values 0x100+i → 8 consecutive `a_rd_valid` pulses in order, with correct data.
- Reset mid-read: assert `n_rst`=0 in the cycle after a read is granted → no `rd_valid` pulse occurs and `rd_data`=0.
